// File: rtl/match_referee_pkg.sv
// Shared types and constants for the volleyball match referee.
package match_referee_pkg;

  typedef enum logic [2:0] {
    ST_SERVE = 3'd0,
    ST_RALLY = 3'd1,
    ST_POINT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic SIDE_P1 = 1'b0;
  localparam logic SIDE_P2 = 1'b1;

  localparam int NET_X_LO_DEF = 500;
  localparam int NET_X_HI_DEF = 523;
  localparam int GROUND_Y_DEF = 700;

  localparam int TOUCH_W = 3;

  function automatic logic [TOUCH_W-1:0] sat_inc(input logic [TOUCH_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/match_referee_touch_tracker.sv
// Per-player touch tracker: collision edge detect, re-touch guard timer and
// saturating touch counter with clear and flush inputs.
module touch_tracker
  import match_referee_pkg::*;
#(
  parameter int GUARD_CYC = 650000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_col,
  input  logic               i_inc,
  input  logic               i_clr,
  input  logic               i_flush,
  output logic               o_touch,
  output logic [TOUCH_W-1:0] o_count
);

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  logic               r_col_sync;
  logic               r_col_prev;
  logic [GW-1:0]      r_guard;
  logic [TOUCH_W-1:0] r_count;

  // An edge is only a touch once the guard window of the previous touch has run out.
  assign o_touch = r_col_sync & ~r_col_prev & (r_guard == '0);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_sync <= 1'b0;
      r_col_prev <= 1'b0;
      r_guard    <= '0;
      r_count    <= '0;
    end else begin
      r_col_sync <= i_col;
      r_col_prev <= r_col_sync;
      if (i_flush) begin
        r_guard <= '0;
        r_count <= '0;
      end else begin
        if (o_touch)
          r_guard <= GW'(GUARD_CYC - 1);
        else if (r_guard != '0)
          r_guard <= r_guard - 1'b1;
        if (i_clr)
          r_count <= '0;
        else if (i_inc)
          r_count <= sat_inc(r_count);
      end
    end
  end

endmodule

// File: rtl/match_referee.sv
// Rally referee: touch counting, fault/landing decisions, scoring, serve and winner.
// Build option: MATCH_REFEREE_WIN_BY_TWO_EN requires a two-point lead (hard cap at max score).
module match_referee
  import match_referee_pkg::*;
#(
  parameter int WIN_SCORE   = 15,
  parameter int MAX_TOUCHES = 3,
  parameter int SCORE_W     = 5,
  parameter int XW          = 12,
  parameter int NET_X_LO    = NET_X_LO_DEF,
  parameter int NET_X_HI    = NET_X_HI_DEF,
  parameter int GUARD_CYC   = 650000,
  parameter int HOLD_CYC    = 65000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_game,
  input  logic               gnd_col,
  input  logic [XW-1:0]      xposball,
  input  logic               col_p1,
  input  logic               col_p2,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [2:0]         touches_p1,
  output logic [2:0]         touches_p2,
  output logic               serve_side,
  output logic               point_valid,
  output logic               point_winner,
  output logic               touch_fault,
  output logic               game_over,
  output logic               winner
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  state_t              r_state, w_state_next;
  logic [SCORE_W-1:0]  r_score1, r_score2;
  logic                r_serve, r_pwin, r_fault, r_last, r_winner;
  logic [HOLD_W-1:0]   r_hold;

  logic w_t1, w_t2, w_acc1, w_acc2, w_ball_p1;
  logic w_inc1, w_inc2, w_clr1, w_clr2;
  logic w_fault1, w_fault2, w_pt_side, w_pt_fault, w_win_cond;

  touch_tracker #(.GUARD_CYC(GUARD_CYC)) u_trk_p1 (
    .clk(clk), .rst_n(rst_n), .i_col(col_p1), .i_inc(w_inc1), .i_clr(w_clr1),
    .i_flush(new_game), .o_touch(w_t1), .o_count(touches_p1)
  );

  touch_tracker #(.GUARD_CYC(GUARD_CYC)) u_trk_p2 (
    .clk(clk), .rst_n(rst_n), .i_col(col_p2), .i_inc(w_inc2), .i_clr(w_clr2),
    .i_flush(new_game), .o_touch(w_t2), .o_count(touches_p2)
  );

  // Simultaneous touches are resolved by which court the ball is over.
  assign w_ball_p1 = (xposball < XW'(NET_X_LO));
  assign w_acc1    = w_t1 & (~w_t2 | w_ball_p1);
  assign w_acc2    = w_t2 & (~w_t1 | ~w_ball_p1);
  assign w_fault1  = (touches_p1 > 3'(MAX_TOUCHES));
  assign w_fault2  = (touches_p2 > 3'(MAX_TOUCHES));

`ifdef MATCH_REFEREE_WIN_BY_TWO_EN
  logic [SCORE_W:0] w_s1x, w_s2x;
  assign w_s1x = {1'b0, r_score1};
  assign w_s2x = {1'b0, r_score2};
  assign w_win_cond = ((r_score1 >= WIN_VAL) && (w_s1x >= w_s2x + (SCORE_W+1)'(2))) ||
                      ((r_score2 >= WIN_VAL) && (w_s2x >= w_s1x + (SCORE_W+1)'(2))) ||
                      (r_score1 == SCORE_MAX) || (r_score2 == SCORE_MAX);
`else
  assign w_win_cond = (r_score1 == WIN_VAL) || (r_score2 == WIN_VAL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_SERVE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pt_side    = SIDE_P1;
    w_pt_fault   = 1'b0;
    unique case (r_state)
      ST_SERVE: if (w_inc1 | w_inc2) w_state_next = ST_RALLY;
      ST_RALLY: begin
        // Touch faults take precedence over a landing in the same cycle.
        if (w_fault1) begin
          w_state_next = ST_POINT;
          w_pt_side    = SIDE_P2;
          w_pt_fault   = 1'b1;
        end else if (w_fault2) begin
          w_state_next = ST_POINT;
          w_pt_side    = SIDE_P1;
          w_pt_fault   = 1'b1;
        end else if (gnd_col) begin
          w_state_next = ST_POINT;
          if (xposball < XW'(NET_X_LO))
            w_pt_side = SIDE_P2;
          else if (xposball > XW'(NET_X_HI))
            w_pt_side = SIDE_P1;
          else
            w_pt_side = ~r_last;
        end
      end
      ST_POINT: w_state_next = ST_HOLD;
      ST_HOLD:  if (r_hold == '0) w_state_next = w_win_cond ? ST_OVER : ST_SERVE;
      ST_OVER:  w_state_next = ST_OVER;
      default:  w_state_next = ST_SERVE;
    endcase
    if (new_game)
      w_state_next = ST_SERVE;
  end

  always_comb begin
    w_inc1      = 1'b0;
    w_inc2      = 1'b0;
    w_clr1      = 1'b0;
    w_clr2      = 1'b0;
    point_valid = (r_state == ST_POINT);
    game_over   = (r_state == ST_OVER);
    touch_fault = (r_state == ST_HOLD) & r_fault;
    unique case (r_state)
      ST_SERVE: begin
        w_inc1 = w_acc1 & (r_serve == SIDE_P1);
        w_inc2 = w_acc2 & (r_serve == SIDE_P2);
      end
      ST_RALLY: begin
        w_inc1 = w_acc1;
        w_inc2 = w_acc2;
        w_clr1 = w_acc2;
        w_clr2 = w_acc1;
      end
      default: begin
        w_clr1 = 1'b1;
        w_clr2 = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score1 <= '0;
      r_score2 <= '0;
      r_serve  <= SIDE_P1;
      r_pwin   <= SIDE_P1;
      r_fault  <= 1'b0;
      r_last   <= SIDE_P1;
      r_winner <= SIDE_P1;
      r_hold   <= '0;
    end else if (new_game) begin
      r_score1 <= '0;
      r_score2 <= '0;
      r_serve  <= SIDE_P1;
      r_pwin   <= SIDE_P1;
      r_fault  <= 1'b0;
      r_last   <= SIDE_P1;
      r_winner <= SIDE_P1;
      r_hold   <= '0;
    end else begin
      if (w_inc1)
        r_last <= SIDE_P1;
      else if (w_inc2)
        r_last <= SIDE_P2;
      unique case (r_state)
        ST_RALLY: if (w_state_next == ST_POINT) begin
          r_pwin  <= w_pt_side;
          r_fault <= w_pt_fault;
        end
        ST_POINT: begin
          if (r_pwin == SIDE_P1 && r_score1 != SCORE_MAX) r_score1 <= r_score1 + 1'b1;
          if (r_pwin == SIDE_P2 && r_score2 != SCORE_MAX) r_score2 <= r_score2 + 1'b1;
          r_serve <= r_pwin;
          r_hold  <= HOLD_W'(HOLD_CYC - 1);
        end
        ST_HOLD: begin
          if (r_hold != '0)
            r_hold <= r_hold - 1'b1;
          else if (w_win_cond)
            r_winner <= r_pwin;
        end
        default: ;
      endcase
    end
  end

  assign score_p1     = r_score1;
  assign score_p2     = r_score2;
  assign serve_side   = r_serve;
  assign point_winner = r_pwin;
  assign winner       = r_winner;

endmodule
